// File: rtl/bus_step_sequencer_pkg.sv
// Shared types and constants for the bus step sequencer: FSM states,
// instruction op encodings and bus-source select bit positions.
package bus_step_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T0,
      T1,
      T2,
      T3,
      T4,
      T5,
      T6
   } state_t;

   typedef enum logic [1:0] {
      OP_ALU    = 2'b00,
      OP_MULDIV = 2'b01,
      OP_MFHI   = 2'b10,
      OP_MFLO   = 2'b11
   } op_t;

   localparam int unsigned REG_N = 16;
   localparam int unsigned SRC_W = 24;

   // src_sel bit positions above the sixteen general registers
   localparam int unsigned SRC_HI     = 16;
   localparam int unsigned SRC_LO     = 17;
   localparam int unsigned SRC_ZHI    = 18;
   localparam int unsigned SRC_ZLO    = 19;
   localparam int unsigned SRC_PC     = 20;
   localparam int unsigned SRC_MDR    = 21;
   localparam int unsigned SRC_INPORT = 22;
   localparam int unsigned SRC_C      = 23;

   // One-hot bus-source select with a single bit at position idx
   function automatic logic [SRC_W-1:0] src_bit(input int unsigned idx);
      return SRC_W'(1) << idx;
   endfunction

endpackage

// File: rtl/bus_step_sequencer_if.sv
// Handshake and datapath-control bundle between an instruction issuer
// (master) and the bus step sequencer (slave).
interface bus_step_sequencer_if;
   import bus_step_sequencer_pkg::*;

   logic                 start;
   logic [1:0]           op;
   logic [3:0]           ra;
   logic [3:0]           rb;
   logic [3:0]           rc;
   logic                 mem_ready;
   logic [SRC_W-1:0]     src_sel;
   logic [REG_N-1:0]     r_in;
   logic                 MARin;
   logic                 PCin;
   logic                 IncPC;
   logic                 MDRread;
   logic                 IRin;
   logic                 Yin;
   logic                 Zin;
   logic                 HIin;
   logic                 LOin;
   logic                 busy;
   logic                 done;

   modport master (
      output start, op, ra, rb, rc, mem_ready,
      input  src_sel, r_in, MARin, PCin, IncPC, MDRread, IRin, Yin, Zin,
             HIin, LOin, busy, done
   );

   modport slave (
      input  start, op, ra, rb, rc, mem_ready,
      output src_sel, r_in, MARin, PCin, IncPC, MDRread, IRin, Yin, Zin,
             HIin, LOin, busy, done
   );

endinterface

// File: rtl/bus_step_sequencer_reg_onehot_dec.sv
// 4-to-16 register-number decoder with enable; output is all-zero when
// disabled so several instances can be OR-ed onto one select vector.
module reg_onehot_dec
   import bus_step_sequencer_pkg::*;
(
   input  logic [3:0]       idx,
   input  logic             en,
   output logic [REG_N-1:0] onehot
);

   // Single bit at the register number, only when enabled
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/bus_step_sequencer.sv
// Bus step sequencer: walks a fetch (T0-T2) and execute (T3-T6) sequence
// per instruction and drives one-hot bus-source selects, register write
// enables and datapath load strobes. All outputs are registered.
module bus_step_sequencer
   import bus_step_sequencer_pkg::*;
(
   input  logic                  clock,
   input  logic                  clear,
   bus_step_sequencer_if.slave   bus
);

   state_t           state;
   state_t           nxt;
   op_t              op_q;
   logic [3:0]       ra_q;
   logic [3:0]       rb_q;
   logic [3:0]       rc_q;

   logic             is_mf;
   logic             rd_rb;
   logic             rd_rc;
   logic             wr_ra;
   logic [REG_N-1:0] dec_rb;
   logic [REG_N-1:0] dec_rc;
   logic [REG_N-1:0] dec_ra;

   logic [SRC_W-1:0] src_n;
   logic             marin_n, pcin_n, incpc_n, mdrread_n, irin_n;
   logic             yin_n, zin_n, hiin_n, loin_n, done_n;

   assign is_mf = (op_q == OP_MFHI) || (op_q == OP_MFLO);

   // Next-state selection; clear overrides everything
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = T0;
         T0:      nxt = T1;
         T1:      if (bus.mem_ready) nxt = T2;
         T2:      nxt = T3;
         T3:      nxt = is_mf ? IDLE : T4;
         T4:      nxt = T5;
         T5:      nxt = (op_q == OP_MULDIV) ? T6 : IDLE;
         T6:      nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (clear) nxt = IDLE;
   end

   // Register-number decode enables for the state being entered
   always_comb begin
      rd_rb = (nxt == T3) && !is_mf;
      rd_rc = (nxt == T4);
      wr_ra = ((nxt == T5) && (op_q == OP_ALU)) || ((nxt == T3) && is_mf);
   end

   reg_onehot_dec u_dec_rb (.idx(rb_q), .en(rd_rb), .onehot(dec_rb));
   reg_onehot_dec u_dec_rc (.idx(rc_q), .en(rd_rc), .onehot(dec_rc));
   reg_onehot_dec u_dec_ra (.idx(ra_q), .en(wr_ra), .onehot(dec_ra));

   // Outputs are decoded from the next state so they can be registered
   // and still line up with the state they belong to
   always_comb begin
      src_n     = {{(SRC_W-REG_N){1'b0}}, dec_rb | dec_rc};
      marin_n   = 1'b0;
      pcin_n    = 1'b0;
      incpc_n   = 1'b0;
      mdrread_n = 1'b0;
      irin_n    = 1'b0;
      yin_n     = 1'b0;
      zin_n     = 1'b0;
      hiin_n    = 1'b0;
      loin_n    = 1'b0;
      done_n    = 1'b0;
      case (nxt)
         T0: begin
            src_n   = src_bit(SRC_PC);
            marin_n = 1'b1;
            incpc_n = 1'b1;
            zin_n   = 1'b1;
         end
         T1: begin
            src_n     = src_bit(SRC_ZLO);
            pcin_n    = 1'b1;
            mdrread_n = 1'b1;
         end
         T2: begin
            src_n  = src_bit(SRC_MDR);
            irin_n = 1'b1;
         end
         T3: begin
            if (is_mf) begin
               src_n  = src_bit((op_q == OP_MFHI) ? SRC_HI : SRC_LO);
               done_n = 1'b1;
            end else begin
               yin_n = 1'b1;
            end
         end
         T4: zin_n = 1'b1;
         T5: begin
            src_n = src_bit(SRC_ZLO);
            if (op_q == OP_MULDIV) loin_n = 1'b1;
            else                   done_n = 1'b1;
         end
         T6: begin
            src_n  = src_bit(SRC_ZHI);
            hiin_n = 1'b1;
            done_n = 1'b1;
         end
         default: src_n = '0;
      endcase
   end

   // State, captured instruction fields and registered outputs
   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         op_q        <= OP_ALU;
         ra_q        <= '0;
         rb_q        <= '0;
         rc_q        <= '0;
         bus.src_sel <= '0;
         bus.r_in    <= '0;
         bus.MARin   <= 1'b0;
         bus.PCin    <= 1'b0;
         bus.IncPC   <= 1'b0;
         bus.MDRread <= 1'b0;
         bus.IRin    <= 1'b0;
         bus.Yin     <= 1'b0;
         bus.Zin     <= 1'b0;
         bus.HIin    <= 1'b0;
         bus.LOin    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.start) begin
            op_q <= op_t'(bus.op);
            ra_q <= bus.ra;
            rb_q <= bus.rb;
            rc_q <= bus.rc;
         end
         bus.src_sel <= src_n;
         bus.r_in    <= dec_ra;
         bus.MARin   <= marin_n;
         bus.PCin    <= pcin_n;
         bus.IncPC   <= incpc_n;
         bus.MDRread <= mdrread_n;
         bus.IRin    <= irin_n;
         bus.Yin     <= yin_n;
         bus.Zin     <= zin_n;
         bus.HIin    <= hiin_n;
         bus.LOin    <= loin_n;
         bus.busy    <= (nxt != IDLE);
         bus.done    <= done_n;
      end
   end

endmodule

// File: tb/tb_bus_step_sequencer.sv
// Directed bench for bus_step_sequencer: an instruction-level model
// (queue of expected bus steps per instruction) checked every cycle,
// plus literal expectations for specific instruction scenarios.
module tb_bus_step_sequencer;
   import bus_step_sequencer_pkg::*;

   localparam int unsigned B_MAR = 8, B_PC = 7, B_INC = 6, B_MDR = 5, B_IR = 4;
   localparam int unsigned B_Y = 3, B_Z = 2, B_HI = 1, B_LO = 0;

   typedef struct packed {
      logic [23:0] src;
      logic [15:0] rin;
      logic [8:0]  strb;
      logic        done;
      logic        wmem;
   } step_t;

   logic clock = 1'b0;
   logic clear;
   bus_step_sequencer_if bus ();

   bus_step_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

   always #5 clock = ~clock;

   int    compared   = 0;
   int    mismatched = 0;
   bit    chk_en     = 0;
   step_t q[$];

   logic [23:0] log_src  [0:31];
   logic [15:0] log_rin  [0:31];
   logic [8:0]  log_strb [0:31];
   logic        log_done [0:31];
   logic        log_busy [0:31];

   function automatic logic [23:0] s24(input int unsigned i);
      return 24'(1) << i;
   endfunction
   function automatic logic [15:0] r16(input int unsigned i);
      return 16'(1) << i;
   endfunction
   function automatic logic [8:0] sb(input int unsigned i);
      return 9'(1) << i;
   endfunction

   function automatic logic [8:0] dut_strb();
      return {bus.MARin, bus.PCin, bus.IncPC, bus.MDRread, bus.IRin,
              bus.Yin, bus.Zin, bus.HIin, bus.LOin};
   endfunction

   function void add(input logic [23:0] s, input logic [15:0] r,
                     input logic [8:0] b, input logic d, input logic w);
      step_t st;
      st.src = s; st.rin = r; st.strb = b; st.done = d; st.wmem = w;
      q.push_back(st);
   endfunction

   // Expected per-cycle bus activity of one instruction
   function void build(input logic [1:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc);
      add(s24(20), '0, sb(B_MAR) | sb(B_INC) | sb(B_Z), 1'b0, 1'b0);
      add(s24(19), '0, sb(B_PC) | sb(B_MDR), 1'b0, 1'b1);
      add(s24(21), '0, sb(B_IR), 1'b0, 1'b0);
      case (op)
         2'b00: begin
            add(s24(32'(rb)), '0, sb(B_Y), 1'b0, 1'b0);
            add(s24(32'(rc)), '0, sb(B_Z), 1'b0, 1'b0);
            add(s24(19), r16(32'(ra)), '0, 1'b1, 1'b0);
         end
         2'b01: begin
            add(s24(32'(rb)), '0, sb(B_Y), 1'b0, 1'b0);
            add(s24(32'(rc)), '0, sb(B_Z), 1'b0, 1'b0);
            add(s24(19), '0, sb(B_LO), 1'b0, 1'b0);
            add(s24(18), '0, sb(B_HI), 1'b1, 1'b0);
         end
         2'b10:   add(s24(16), r16(32'(ra)), '0, 1'b1, 1'b0);
         default: add(s24(17), r16(32'(ra)), '0, 1'b1, 1'b0);
      endcase
   endfunction

   // Model: advance one step per clock, hold the fetch-wait step until
   // memory is ready, accept a new instruction only when empty
   always @(posedge clock) begin
      if (clear) q.delete();
      else if (q.size() == 0) begin
         if (bus.start) build(bus.op, bus.ra, bus.rb, bus.rc);
      end else if (q[0].wmem && !bus.mem_ready) begin
      end else begin
         void'(q.pop_front());
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clock) begin
      if (chk_en) begin
         step_t e;
         step_t a;
         e = (q.size() != 0) ? q[0] : '0;
         e.wmem = 1'b0;
         a = {bus.src_sel, bus.r_in, dut_strb(), bus.done, 1'b0};
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL model_outputs t=%0t: src=%h rin=%h strb=%h done=%b expected src=%h rin=%h strb=%h done=%b",
                     $time, a.src, a.rin, a.strb, a.done, e.src, e.rin, e.strb, e.done);
         end
         compared++;
         if (bus.busy !== (q.size() != 0)) begin
            mismatched++;
            $display("FAIL model_busy t=%0t: got %b expected %b", $time, bus.busy, q.size() != 0);
         end
         compared++;
         if (!$onehot0(bus.src_sel) || !$onehot0(bus.r_in)) begin
            mismatched++;
            $display("FAIL onehot0 t=%0t: src_sel=%h r_in=%h", $time, bus.src_sel, bus.r_in);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rc);
      bus.op = op; bus.ra = ra; bus.rb = rb; bus.rc = rc;
      bus.start = 1'b1;
   endtask

   // Log cycles 1..n after the start-sampling edge, applying scheduled input changes
   task automatic run(input int n, input int mr_at, input int clr_at, input int stop_at);
      for (int c = 1; c <= n; c++) begin
         @(negedge clock);
         log_src[c]  = bus.src_sel;
         log_rin[c]  = bus.r_in;
         log_strb[c] = dut_strb();
         log_done[c] = bus.done;
         log_busy[c] = bus.busy;
         if (c == stop_at) bus.start = 1'b0;
         if (c == mr_at) bus.mem_ready = 1'b1;
         if (c == clr_at) clear = 1'b1;
         if (c == clr_at + 1) clear = 1'b0;
      end
   endtask

   function automatic int first_done(input int n);
      for (int c = 1; c <= n; c++) if (log_done[c] === 1'b1) return c;
      return 0;
   endfunction

   function automatic int count_done(input int n);
      int k = 0;
      for (int c = 1; c <= n; c++) if (log_done[c] === 1'b1) k++;
      return k;
   endfunction

   logic [23:0] alu_seq [1:6];

   initial begin
      clear = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.ra = '0; bus.rb = '0; bus.rc = '0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear = 1'b0;
      chk("reset_outputs", {bus.src_sel, bus.busy, bus.done, dut_strb()}, '0);
      chk("reset_rin", {16'h0, bus.r_in}, '0);
      chk_en = 1;

      // ALU ra=3 rb=1 rc=2, memory always ready
      alu_seq = '{24'h100000, 24'h080000, 24'h200000, 24'h000002, 24'h000004, 24'h080000};
      issue(2'b00, 4'd3, 4'd1, 4'd2);
      run(8, 0, 0, 1);
      for (int c = 1; c <= 6; c++) chk($sformatf("alu_src_c%0d", c), {8'h0, log_src[c]}, {8'h0, alu_seq[c]});
      chk("alu_rin_t5", {16'h0, log_rin[6]}, 32'h0008);
      chk("alu_done_cycle", first_done(8), 6);
      chk("alu_busy_after", {31'h0, log_busy[7]}, 0);

      // MULDIV with memory not ready for three cycles in T1
      bus.mem_ready = 1'b0;
      issue(2'b01, 4'd5, 4'd6, 4'd7);
      run(12, 5, 0, 1);
      for (int c = 2; c <= 5; c++) begin
         chk($sformatf("muldiv_t1_src_c%0d", c), {8'h0, log_src[c]}, 32'h080000);
         chk($sformatf("muldiv_t1_strb_c%0d", c), {23'h0, log_strb[c]}, 32'h0A0);
      end
      chk("muldiv_t2_src", {8'h0, log_src[6]}, 32'h200000);
      chk("muldiv_loin_t5", {23'h0, log_strb[9]}, 32'h001);
      chk("muldiv_hiin_t6", {23'h0, log_strb[10]}, 32'h002);
      chk("muldiv_done_cycle", first_done(12), 10);
      chk("muldiv_done_count", count_done(12), 1);

      // MFLO into R15
      issue(2'b11, 4'd15, 4'd0, 4'd0);
      run(6, 0, 0, 1);
      chk("mflo_src_t3", {8'h0, log_src[4]}, 32'h020000);
      chk("mflo_rin_t3", {16'h0, log_rin[4]}, 32'h8000);
      chk("mflo_done_cycle", first_done(6), 4);
      chk("mflo_busy_after", {31'h0, log_busy[5]}, 0);

      // start held for 20 cycles: three back-to-back ALU instructions
      issue(2'b00, 4'd4, 4'd8, 4'd12);
      run(24, 0, 0, 20);
      chk("b2b_done_count", count_done(24), 3);
      chk("b2b_done_c6", {31'h0, log_done[6]}, 1);
      chk("b2b_done_c13", {31'h0, log_done[13]}, 1);
      chk("b2b_done_c20", {31'h0, log_done[20]}, 1);
      chk("b2b_idle_c7", {30'h0, log_busy[7], log_busy[14]}, 0);
      chk("b2b_busy_c8", {31'h0, log_busy[8]}, 1);

      // clear during T4 aborts the instruction
      issue(2'b00, 4'd1, 4'd2, 4'd3);
      run(10, 0, 5, 1);
      chk("clr_was_t4", {8'h0, log_src[5]}, 32'h000008);
      chk("clr_outputs_zero", {log_src[6], log_busy[6], log_done[6], log_strb[6]}, 0);
      chk("clr_rin_zero", {16'h0, log_rin[6]}, 0);
      chk("clr_no_done", count_done(10), 0);

      // clear overrides start while idle
      bus.start = 1'b1; clear = 1'b1;
      @(negedge clock);
      chk("clr_over_start_busy", {31'h0, bus.busy}, 0);
      bus.start = 1'b0; clear = 1'b0;

      // ra = rb = rc is legal
      issue(2'b01, 4'd9, 4'd9, 4'd9);
      run(10, 0, 0, 1);
      chk("same_reg_t3", {8'h0, log_src[4]}, 32'h000200);
      chk("same_reg_t4", {8'h0, log_src[5]}, 32'h000200);
      chk("same_reg_done", first_done(10), 7);

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bus_step_sequencer.md
BUS_STEP_SEQUENCER -- requirements
Module: bus_step_sequencer

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have the port clear, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: begin one instruction; sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: 00 ALU, 01 MULDIV, 10 MFHI, 11 MFLO; captured with start.
REQ-005 The block SHALL have the ports ra, rb and rc, input, 4 bits each: destination, source A and source B register numbers; captured with start.
REQ-006 The block SHALL have the port mem_ready, input, 1 bit: memory read data valid.
REQ-007 The block SHALL have the port src_sel, output, 24 bits, one-hot bus-source selects: [15:0] R0..R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C.
REQ-008 The block SHALL have the port r_in, output, 16 bits: register write enables R0..R15.
REQ-009 The block SHALL have the ports MARin, PCin, IncPC, MDRread, IRin, Yin, Zin, HIin and LOin, output, 1 bit each: datapath load strobes.
REQ-010 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have the port done, output, 1 bit: single-cycle pulse in the last step of an instruction.

Function
REQ-012 The FSM SHALL use the states IDLE, T0, T1, T2, T3, T4, T5, T6, each lasting at least one clock.
REQ-013 All outputs SHALL be decoded from the registered state and the captured fields (Moore), with zero combinational path from start or op.
REQ-014 In IDLE, start=1 SHALL capture op/ra/rb/rc and move to T0 on the next edge; start=0 SHALL keep the FSM in IDLE.
REQ-015 T0 SHALL assert src_sel[20], MARin, IncPC and Zin, then go to T1.
REQ-016 T1 SHALL assert src_sel[19], PCin and MDRread, and SHALL hold all of them while mem_ready=0; mem_ready=1 SHALL advance it to T2.
REQ-017 T2 SHALL assert src_sel[21] and IRin, then go to T3.
REQ-018 For ALU/MULDIV, T3 SHALL assert src_sel[rb] and Yin; T4 SHALL assert src_sel[rc] and Zin.
REQ-019 For ALU, T5 SHALL assert src_sel[19] and r_in[ra] and pulse done, then return to IDLE.
REQ-020 For MULDIV, T5 SHALL assert src_sel[19] and LOin; T6 SHALL assert src_sel[18] and HIin and pulse done, then return to IDLE.
REQ-021 For MFHI/MFLO, T3 SHALL assert src_sel[16] (MFHI) or src_sel[17] (MFLO) together with r_in[ra], pulse done, then return to IDLE.
REQ-022 At most one src_sel bit SHALL be high in any cycle; src_sel SHALL be all-zero in IDLE.
REQ-023 At most one r_in bit SHALL be high in any cycle.
REQ-024 ra=rb=rc SHALL be legal, with no special-casing.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 Back-to-back instructions SHALL be supported: start high in the cycle after done SHALL enter T0 on the next edge.
REQ-027 Latency from start to done SHALL be 6 cycles for ALU, 7 for MULDIV and 4 for MFHI/MFLO, each plus the mem_ready wait cycles.

Reset
REQ-028 clear=1 at a rising edge SHALL force IDLE and zero the captured fields, overriding start and mem_ready.
REQ-029 clear mid-instruction, in any state, SHALL abort the instruction without issuing done.
REQ-030 Every output SHALL be 0 in the cycle after reset, including busy and done.

Structure
REQ-031 A shared package SHALL hold the state enum, the op encodings and the src_sel bit-index constants (SRC_HI=16 .. SRC_C=23).
REQ-032 The 4-to-16 register one-hot decode for src_sel and r_in SHALL be one sub-module, reg_onehot_dec, instantiated for the rb, rc and ra paths.

Verification
REQ-033 Reset then ALU op, ra=3, rb=1, rc=2, mem_ready tied 1 -> bus sources in order: src_sel bit 20, 19, 21, bit 1, bit 2, 19; r_in=0x0008 in T5; done at cycle 6.
REQ-034 MULDIV op with mem_ready low for 3 cycles in T1 -> T1 held for 4 cycles with outputs stable; LOin in T5, HIin in T6; done at cycle 10.
REQ-035 MFLO op, ra=15 -> src_sel[17] and r_in=0x8000 in T3; done at cycle 4; busy low the next cycle.
REQ-036 start held high for 20 cycles -> three back-to-back ALU instructions; starts during busy are dropped; done pulses exactly 1 cycle each.
REQ-037 clear asserted in T4 -> IDLE next cycle; all outputs zero; no done pulse.
REQ-038 Bench assertion across all tests -> $onehot0(src_sel) and $onehot0(r_in) hold every cycle.
